// File: rtl/qdi_1of2_sync_rx.sv
// Clocked receiver for a 4-phase QDI 1-of-2 dual-rail channel.
// The rails are synchronized and qualified as stable before they are used.
// Decoded bits go into a small FIFO with a valid/ready head. The block also
// drives the sender's enable, counts accepted tokens and flags illegal 11 codes.
module qdi_1of2_sync_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [1:0]       Rx,
   output logic             Rxe,
   output logic             out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] tok_count,
   output logic             err,
   output logic             fifo_full
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = SYNC_STAGES + 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_NEUTRAL, S_REQ, S_ACK, S_HOLD} state_t;

   state_t                        state_q, state_d;
   logic [SYNC_STAGES-1:0][1:0]   sync_q;
   logic [PW-1:0]                 vld_q;
   logic [1:0]                    rs, rq;
   logic                          stable;
   logic                          push, pop, set_err;
   logic [FIFO_DEPTH-1:0]         mem_q;
   logic [AW-1:0]                 wr_q, rd_q;
   logic [AW:0]                   cnt_q, cnt_d;
   logic [CNT_W-1:0]              tok_q;
   logic                          err_q;

   // Rail synchronizer chain; stage 0 samples the asynchronous rails.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], Rx};
   end

   // The stability compare is trusted only once the whole chain holds real
   // samples. This keeps the cleared reset value from looking like a neutral
   // code.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) vld_q <= '0;
      else       vld_q <= {vld_q[PW-2:0], 1'b1};
   end

   // rq is the fully synchronized code. rs is the same code one stage earlier,
   // so rs==rq means the rails held one value over two consecutive samples.
   assign rs     = sync_q[SYNC_STAGES-2];
   assign rq     = sync_q[SYNC_STAGES-1];
   assign stable = vld_q[PW-1] && (rs == rq);

   // FIFO occupancy after this edge's push/pop.
   always_comb begin
      cnt_d = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (!push && pop) cnt_d = cnt_q - 1'b1;
   end

   // Handshake state register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= S_NEUTRAL;
      else       state_q <= state_d;
   end

   // Next-state: request only on a stable neutral code with room in the FIFO.
   // Acknowledge on any stable non-neutral code.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_NEUTRAL: if (stable && rq == 2'b00 && !fifo_full) state_d = S_REQ;
         S_REQ:     if (stable && rq != 2'b00)               state_d = S_ACK;
         S_ACK:     if (stable && rq == 2'b00)
                       state_d = (cnt_d == FULL_CNT) ? S_HOLD : S_REQ;
         S_HOLD:    if (!fifo_full)                          state_d = S_REQ;
         default:   state_d = S_NEUTRAL;
      endcase
   end

   // Outputs: Rxe comes straight from the state flop, so it is glitch-free and
   // clears asynchronously on reset.
   always_comb begin
      Rxe     = (state_q == S_REQ);
      push    = (state_q == S_REQ) && stable && (rq == 2'b01 || rq == 2'b10);
      set_err = (state_q == S_REQ) && stable && (rq == 2'b11);
   end

   assign pop = out_valid && out_ready;

   // FIFO storage and pointers. A push is never issued when the FIFO is full.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mem_q <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= rq[1];
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   // Token counter wraps silently. The error flag is sticky until reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         tok_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (push)    tok_q <= tok_q + CNT_W'(1);
         if (set_err) err_q <= 1'b1;
      end
   end

   assign out_data  = mem_q[rd_q];
   assign out_valid = (cnt_q != '0);
   assign fifo_full = (cnt_q == FULL_CNT);
   assign tok_count = tok_q;
   assign err       = err_q;

endmodule

// File: tb/tb_qdi_1of2_sync_rx.sv
// Bench for qdi_1of2_sync_rx. A 4-phase sender model drives the rails, and a
// queue-based model of the receiver is checked against the DUT on every cycle.
module tb_qdi_1of2_sync_rx;

   localparam int SS    = 2;
   localparam int DEPTH = 4;
   localparam int CW    = 4;

   logic          CLK = 1'b0;
   logic          RESET;
   logic [1:0]    Rx;
   logic          Rxe, out_data, out_valid, out_ready, err, fifo_full;
   logic [CW-1:0] tok_count;

   int  checks = 0;
   int  errors = 0;
   bit  rand_ready = 0;
   bit  sdone;

   // model state
   bit         mq[$];
   int         mtok;
   bit         merr;
   logic       prev_rxe;
   logic [1:0] prev_rx;
   bit         prev_pop;
   bit         dut_log[$];

   qdi_1of2_sync_rx #(.SYNC_STAGES(SS), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .CLK(CLK), .RESET(RESET), .Rx(Rx), .Rxe(Rxe), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .tok_count(tok_count),
      .err(err), .fifo_full(fifo_full));

   always #5 CLK = ~CLK;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   // Bounded wait for Rxe to reach v; n returns the number of edges taken.
   task automatic wait_rxe(input logic v, output int n);
      n = 0;
      while (Rxe !== v && n < 400) begin tick(); n++; end
      if (Rxe !== v) begin
         checks++; errors++;
         $display("FAIL wait_rxe: Rxe=%b after %0d cycles, required %b", Rxe, n, v);
      end
   endtask

   // One 4-phase token: wait for request, optionally show a 1-cycle 11 skew
   // glitch, hold the code until acknowledge, then return to neutral.
   task automatic send(input logic [1:0] code, input bit glitch, input int d1,
                       input int d2, output int rl, output int fl);
      wait_rxe(1'b1, rl);
      repeat (d1) tick();
      if (glitch) begin Rx = 2'b11; tick(); end
      Rx = code;
      wait_rxe(1'b0, fl);
      repeat (d2) tick();
      Rx = 2'b00;
   endtask

   task automatic hold_sender();
      bit bits[6] = '{1, 1, 0, 1, 0, 0};
      int rl, fl;
      for (int i = 0; i < 6; i++) send(bits[i] ? 2'b10 : 2'b01, 0, 0, 0, rl, fl);
      sdone = 1;
   endtask

   always @(posedge CLK) if (rand_ready) begin #1; out_ready = 1'($urandom_range(0, 1)); end

   // Model and per-cycle compare. A falling Rxe marks the acceptance edge; the
   // code the sender held across that edge decides between a push and an error.
   always @(negedge CLK) begin
      if (RESET) begin
         mq.delete(); mtok = 0; merr = 0;
         prev_rxe = 0; prev_rx = 2'b00; prev_pop = 0;
      end else begin
         if (prev_pop && mq.size() > 0) mq.delete(0);
         if (prev_rxe && !Rxe) begin
            if (prev_rx == 2'b11) merr = 1;
            else if (prev_rx == 2'b01 || prev_rx == 2'b10) begin
               mq.push_back(prev_rx[1]); mtok++;
            end else chk("rxe_fall_code", 32'(prev_rx), 32'd1);
         end
         if (!prev_rxe && Rxe) chk("rxe_rise_neutral", 32'(prev_rx), 32'd0);
         chk("out_valid", out_valid, mq.size() > 0);
         if (mq.size() > 0) chk("out_data", out_data, mq[0]);
         chk("fifo_full", fifo_full, mq.size() == DEPTH);
         chk("tok_count", tok_count, mtok % (1 << CW));
         chk("err", err, merr);
         if (out_valid && out_ready) dut_log.push_back(out_data);
         prev_pop = (mq.size() > 0) && out_ready;
         prev_rxe = Rxe;
         prev_rx  = Rx;
      end
   end

   initial begin
      int rl, fl, n;
      bit b4[4] = '{1, 0, 1, 1};
      bit b6[6] = '{1, 1, 0, 1, 0, 0};
      RESET = 1; Rx = 2'b00; out_ready = 0;
      repeat (3) tick();
      chk("rst_rxe", Rxe, 0); chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0); chk("rst_tok", tok_count, 0);
      chk("rst_err", err, 0); chk("rst_full", fifo_full, 0);
      RESET = 0;
      wait_rxe(1'b1, rl);
      chk("reset_rise_lat", rl, SS + 2);
      chk("idle_valid", out_valid, 0); chk("idle_tok", tok_count, 0);
      chk("idle_err", err, 0); chk("idle_full", fifo_full, 0);

      // basic sequence 1,0,1,1
      out_ready = 1; dut_log.delete();
      for (int i = 0; i < 4; i++) begin
         send(b4[i] ? 2'b10 : 2'b01, 0, 0, 0, rl, fl);
         if (i > 0) chk("rise_lat", rl, SS + 1);
         chk("fall_lat", fl, SS + 1);
      end
      wait_rxe(1'b1, rl); chk("rise_lat_last", rl, SS + 1);
      repeat (4) tick();
      chk("basic_log_n", dut_log.size(), 4);
      for (int i = 0; i < 4 && i < dut_log.size(); i++) chk("basic_log", dut_log[i], b4[i]);
      chk("basic_tok", tok_count, 4); chk("basic_err", err, 0);

      // back-pressure: 6 tokens into a 4-deep FIFO
      out_ready = 0; dut_log.delete(); sdone = 0;
      fork hold_sender(); join_none
      repeat (40) tick();
      chk("hold_full", fifo_full, 1); chk("hold_rxe", Rxe, 0);
      chk("hold_tok", tok_count, 8); chk("hold_valid", out_valid, 1);
      out_ready = 1;
      n = 0;
      while (!sdone && n < 2000) begin tick(); n++; end
      chk("hold_done", sdone, 1);
      repeat (6) tick();
      chk("hold_log_n", dut_log.size(), 6);
      for (int i = 0; i < 6 && i < dut_log.size(); i++) chk("hold_log", dut_log[i], b6[i]);
      chk("hold_tok_end", tok_count, 10);

      // rail skew: 01 and 11 each for one cycle, then 10 held
      wait_rxe(1'b1, rl); dut_log.delete();
      Rx = 2'b01; tick(); Rx = 2'b11; tick(); Rx = 2'b10;
      wait_rxe(1'b0, fl); chk("skew_fall_lat", fl, SS + 1);
      Rx = 2'b00;
      wait_rxe(1'b1, rl); chk("skew_rise_lat", rl, SS + 1);
      chk("skew_err", err, 0); chk("skew_tok", tok_count, 11);
      chk("skew_log_n", dut_log.size(), 1);
      if (dut_log.size() > 0) chk("skew_bit", dut_log[0], 1);

      // illegal code held, then recovery
      send(2'b11, 0, 0, 0, rl, fl); chk("ill_fall_lat", fl, SS + 1);
      wait_rxe(1'b1, rl);
      chk("ill_err", err, 1); chk("ill_tok", tok_count, 11); chk("ill_valid", out_valid, 0);
      send(2'b01, 0, 0, 0, rl, fl);
      repeat (5) tick();
      chk("rec_tok", tok_count, 12); chk("rec_err", err, 1);

      // randomized traffic
      rand_ready = 1;
      for (int i = 0; i < 150; i++) begin
         logic [1:0] c;
         c = ($urandom_range(0, 9) == 0) ? 2'b11 : ($urandom_range(0, 1) ? 2'b10 : 2'b01);
         send(c, $urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 3), rl, fl);
      end
      rand_ready = 0; #2; out_ready = 1;
      repeat (12) tick();

      // reset in the middle of a handshake
      wait_rxe(1'b1, rl);
      Rx = 2'b10;
      wait_rxe(1'b0, fl);
      RESET = 1; #1;
      chk("mid_rst_rxe", Rxe, 0); chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_data", out_data, 0); chk("mid_rst_tok", tok_count, 0);
      chk("mid_rst_err", err, 0); chk("mid_rst_full", fifo_full, 0);
      tick(); tick();
      RESET = 0;
      for (int i = 0; i < 10; i++) begin tick(); chk("post_rst_rxe", Rxe, 0); end
      Rx = 2'b00;
      wait_rxe(1'b1, rl); chk("post_rst_rise_lat", rl, SS + 1);
      send(2'b10, 0, 0, 0, rl, fl);
      repeat (4) tick();
      chk("post_rst_tok", tok_count, 1);

      // 17 tokens since reset with a 4-bit counter
      for (int i = 0; i < 16; i++) send($urandom_range(0, 1) ? 2'b10 : 2'b01, 0, 0, 0, rl, fl);
      repeat (4) tick();
      chk("wrap_tok", tok_count, 1); chk("wrap_err", err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
